// File: rtl/i2c_master_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_master_arbiter
// Arbitrates between two requesters that share one byte-level I2C write
// master ([START][addr<<1|W][data][STOP]). The grant is round-robin. The
// granted operands are latched once and held stable for the master. The
// requester gets a one-cycle done pulse with nack/timeout status.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   When it is defined, a WAIT-state watchdog ends a transaction that stalls
//   for TIMEOUT_CYCLES cycles. The watchdog reports nack=1 and
//   timeout_err=1. When it is undefined, WAIT only exits on m_done and
//   timeout_err is tied low.
//
// Ports
//   clk, rst_n          : system clock; async active-low reset
//   req0/1              : requests, held high until the matching done pulse
//   addr0/1, data0/1    : 7-bit slave address and write byte per requester
//   gnt[1:0]            : one-hot grant, high from grant through RESP
//   done[1:0]           : one-cycle completion pulse per requester
//   nack, timeout_err   : status, valid in the done cycle
//   m_start             : one-cycle start pulse to the I2C master
//   m_addr, m_wdata     : master operands, held from m_start to m_done
//   m_busy, m_done      : master busy level and end-of-transaction pulse
//   m_nack              : master ACK status, valid with m_done
// ---------------------------------------------------------------------------
module i2c_master_arbiter #(
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [6:0] addr0,
    input  logic [6:0] addr1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic       nack,
    output logic       timeout_err,
    output logic       m_start,
    output logic [6:0] m_addr,
    output logic [7:0] m_wdata,
    input  logic       m_busy,
    input  logic       m_done,
    input  logic       m_nack
);

    // The watchdog counter is 20 bits wide, so the limit must fit.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 1048575) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 2..2^20-1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t     r_state;
    logic       r_last;     // index of the requester granted most recently
    logic [1:0] r_gnt;
    logic [1:0] r_done;
    logic       r_nack;
    logic       r_start;
    logic [6:0] r_addr;
    logic [7:0] r_wdata;

`ifdef ARB_TIMEOUT_EN
    localparam logic [19:0] LP_TMO_LAST = 20'(TIMEOUT_CYCLES - 1);
    logic [19:0] r_cnt;
    logic        r_tmo;
`endif

    // On a tie, requester 1 wins only if requester 0 was granted last.
    logic w_pick1;
    assign w_pick1 = req1 & (~req0 | ~r_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_gnt   <= 2'b00;
            r_done  <= 2'b00;
            r_nack  <= 1'b0;
            r_start <= 1'b0;
            r_addr  <= 7'h00;
            r_wdata <= 8'h00;
`ifdef ARB_TIMEOUT_EN
            r_cnt   <= 20'd0;
            r_tmo   <= 1'b0;
`endif
        end else begin
            r_start <= 1'b0;
            r_done  <= 2'b00;
            case (r_state)
                IDLE: begin
                    if (req0 || req1) begin
                        r_gnt   <= w_pick1 ? 2'b10 : 2'b01;
                        r_addr  <= w_pick1 ? addr1 : addr0;
                        r_wdata <= w_pick1 ? data1 : data0;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!m_busy) begin
                        r_start <= 1'b1;
                        r_state <= WAIT;
`ifdef ARB_TIMEOUT_EN
                        r_cnt   <= 20'd0;
`endif
                    end
                end
                WAIT: begin
                    if (m_done) begin
                        r_nack  <= m_nack;
                        r_done  <= r_gnt;
                        r_state <= RESP;
`ifdef ARB_TIMEOUT_EN
                        r_tmo   <= 1'b0;
                    end else if (r_cnt == LP_TMO_LAST) begin
                        r_nack  <= 1'b1;
                        r_tmo   <= 1'b1;
                        r_done  <= r_gnt;
                        r_state <= RESP;
                    end else begin
                        r_cnt   <= r_cnt + 20'd1;
`endif
                    end
                end
                RESP: begin
                    // done is high in this cycle; release the grant on exit.
                    r_gnt   <= 2'b00;
                    r_last  <= r_gnt[1];
                    r_nack  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
                    r_tmo   <= 1'b0;
`endif
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign done    = r_done;
    assign nack    = r_nack;
    assign m_start = r_start;
    assign m_addr  = r_addr;
    assign m_wdata = r_wdata;
`ifdef ARB_TIMEOUT_EN
    assign timeout_err = r_tmo;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_master_arbiter.sv
module tb_i2c_master_arbiter;

    logic       clk, rst_n, req0, req1, m_busy, m_done, m_nack;
    logic [6:0] addr0, addr1, m_addr;
    logic [7:0] data0, data1, m_wdata;
    logic [1:0] gnt, done;
    logic       nack, timeout_err, m_start;

    int checks = 0;
    int errors = 0;

    // Master model controls, written only by the main sequence.
    int         delay    = 50;
    logic       model_en = 1'b1;
    // Model state, written only by the model process.
    int         starts   = 0;
    int         pend_cnt = 0;
    logic       pend_nack = 1'b0;

    i2c_master_arbiter #(.TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1),
        .data0(data0), .data1(data1),
        .gnt(gnt), .done(done), .nack(nack), .timeout_err(timeout_err),
        .m_start(m_start), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_busy(m_busy), .m_done(m_done), .m_nack(m_nack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-level master model: m_done pulses 'delay' cycles after m_start,
    // NACKing only for address 0x57.
    initial begin
        m_done = 1'b0;
        m_nack = 1'b0;
        forever begin
            @(posedge clk); #1;
            m_done = 1'b0;
            m_nack = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt = pend_cnt - 1;
                if (pend_cnt == 0 && model_en) begin
                    m_done = 1'b1;
                    m_nack = pend_nack;
                end
            end
            if (m_start) begin
                starts    = starts + 1;
                pend_cnt  = delay;
                pend_nack = (m_addr == 7'h57);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done == 2'b00 && cyc < 2000) begin tick; cyc++; end
        if (done == 2'b00) cyc = -1;
    endtask

    task automatic wait_start(output int cyc);
        cyc = 0;
        while (!m_start && cyc < 2000) begin tick; cyc++; end
        if (!m_start) cyc = -1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; m_busy = 1'b0;
        addr0 = 7'h00; addr1 = 7'h00; data0 = 8'h00; data1 = 8'h00;
        repeat (3) tick;
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b exp 00", gnt); end
        checks++; if (done !== 2'b00) begin errors++; $display("FAIL reset_done got %b exp 00", done); end
        checks++; if (m_start !== 1'b0) begin errors++; $display("FAIL reset_mstart got %b exp 0", m_start); end
        checks++; if ({nack, timeout_err} !== 2'b00) begin errors++; $display("FAIL reset_status got %b exp 00", {nack, timeout_err}); end
        checks++; if ({m_addr, m_wdata} !== 15'h0) begin errors++; $display("FAIL reset_operands got %h exp 0", {m_addr, m_wdata}); end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_single;
        int c;
        delay = 50;
        addr0 = 7'h56; data0 = 8'h0A; req0 = 1'b1;
        tick;
        checks++; if ({gnt, m_start} !== 3'b010) begin errors++; $display("FAIL single_grant got %b exp 010", {gnt, m_start}); end
        tick;
        checks++; if (m_start !== 1'b1) begin errors++; $display("FAIL single_start_lat got %b exp 1", m_start); end
        checks++; if ({m_addr, m_wdata} !== {7'h56, 8'h0A}) begin errors++; $display("FAIL single_operands got %h exp %h", {m_addr, m_wdata}, {7'h56, 8'h0A}); end
        tick;
        checks++; if (m_start !== 1'b0) begin errors++; $display("FAIL single_start_width got %b exp 0", m_start); end
        wait_done(c);
        checks++; if (c !== 50) begin errors++; $display("FAIL single_done_lat got %0d exp 50", c); end
        checks++; if ({done, gnt, nack, timeout_err} !== 6'b010100) begin errors++; $display("FAIL single_done got %b exp 010100", {done, gnt, nack, timeout_err}); end
        req0 = 1'b0;
        tick;
        checks++; if ({done, gnt} !== 4'b0000) begin errors++; $display("FAIL single_release got %b exp 0000", {done, gnt}); end
    endtask

    task automatic test_round_robin;
        int c;
        logic [1:0] exp_g [3];
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
        rst_n = 1'b0; tick; rst_n = 1'b1; tick;
        delay = 5;
        addr0 = 7'h11; data0 = 8'h01; addr1 = 7'h22; data1 = 8'h02;
        for (int r = 0; r < 3; r++) begin
            req0 = 1'b1; req1 = 1'b1;
            tick;
            checks++; if (gnt !== exp_g[r]) begin errors++; $display("FAIL rr_gnt round %0d got %b exp %b", r, gnt, exp_g[r]); end
            wait_done(c);
            checks++; if (done !== exp_g[r]) begin errors++; $display("FAIL rr_done round %0d got %b exp %b", r, done, exp_g[r]); end
            req0 = 1'b0; req1 = 1'b0;
            tick; tick;
        end
    endtask

    task automatic test_back_to_back;
        int c;
        delay = 5;
        req0 = 1'b1; req1 = 1'b1;
        tick;
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL b2b_first got %b exp 10", gnt); end
        wait_done(c);
        req1 = 1'b0;
        tick;
        checks++; if ({gnt, done} !== 4'b0000) begin errors++; $display("FAIL b2b_gap got %b exp 0000", {gnt, done}); end
        tick;
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL b2b_second got %b exp 01", gnt); end
        wait_done(c);
        checks++; if (done !== 2'b01) begin errors++; $display("FAIL b2b_done got %b exp 01", done); end
        req0 = 1'b0;
        tick;
    endtask

    task automatic test_nack;
        int c;
        delay = 8;
        addr1 = 7'h57; data1 = 8'h33; req1 = 1'b1;
        wait_done(c);
        checks++; if ({done, nack} !== 3'b101) begin errors++; $display("FAIL nack_done got %b exp 101", {done, nack}); end
        req1 = 1'b0;
        tick;
        addr0 = 7'h56; data0 = 8'h44; req0 = 1'b1;
        wait_done(c);
        checks++; if ({done, nack} !== 3'b010) begin errors++; $display("FAIL nack_next got %b exp 010", {done, nack}); end
        req0 = 1'b0;
        tick;
    endtask

    task automatic test_busy;
        int c, s0, seen;
        delay = 6;
        m_busy = 1'b1;
        addr0 = 7'h21; data0 = 8'h5A; s0 = starts; req0 = 1'b1;
        tick;
        // Changing operands and dropping req must neither re-sample nor abort.
        addr0 = 7'h7F; data0 = 8'hFF; req0 = 1'b0;
        seen = 0;
        repeat (20) begin tick; if (m_start) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL busy_hold starts got %0d exp 0", seen); end
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL busy_gnt got %b exp 01", gnt); end
        m_busy = 1'b0;
        wait_start(c);
        checks++; if (c !== 1) begin errors++; $display("FAIL busy_release_lat got %0d exp 1", c); end
        checks++; if ({m_addr, m_wdata} !== {7'h21, 8'h5A}) begin errors++; $display("FAIL busy_operands got %h exp %h", {m_addr, m_wdata}, {7'h21, 8'h5A}); end
        wait_done(c);
        checks++; if (done !== 2'b01) begin errors++; $display("FAIL busy_done got %b exp 01", done); end
        checks++; if (starts - s0 !== 1) begin errors++; $display("FAIL busy_start_count got %0d exp 1", starts - s0); end
        tick;
    endtask

    task automatic test_timeout;
        int c;
        model_en = 1'b0;
        delay = 5;
        addr0 = 7'h10; data0 = 8'h99; req0 = 1'b1;
        wait_start(c);
        checks++; if (c !== 2) begin errors++; $display("FAIL tmo_start_lat got %0d exp 2", c); end
`ifdef ARB_TIMEOUT_EN
        wait_done(c);
        checks++; if (c !== 100) begin errors++; $display("FAIL tmo_lat got %0d exp 100", c); end
        checks++; if ({done, timeout_err, nack} !== 4'b0111) begin errors++; $display("FAIL tmo_status got %b exp 0111", {done, timeout_err, nack}); end
        req0 = 1'b0;
        tick;
`else
        c = 0;
        repeat (300) begin tick; if (done !== 2'b00 || timeout_err !== 1'b0) c++; end
        checks++; if (c !== 0) begin errors++; $display("FAIL no_tmo_stuck done seen %0d exp 0", c); end
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL no_tmo_gnt got %b exp 01", gnt); end
        req0 = 1'b0;
        rst_n = 1'b0; tick; rst_n = 1'b1; tick;
`endif
        model_en = 1'b1;
        tick;
    endtask

    task automatic test_reset_mid;
        int c, bad;
        delay = 40;
        addr1 = 7'h56; data1 = 8'h77; req1 = 1'b1;
        wait_start(c);
        repeat (10) tick;
        rst_n = 1'b0; #1;
        checks++; if ({gnt, done, m_start, nack, timeout_err} !== 7'b0) begin errors++; $display("FAIL midrst_ctrl got %b exp 0", {gnt, done, m_start, nack, timeout_err}); end
        checks++; if ({m_addr, m_wdata} !== 15'h0) begin errors++; $display("FAIL midrst_operands got %h exp 0", {m_addr, m_wdata}); end
        req1 = 1'b0;
        tick;
        rst_n = 1'b1;
        // The stale master m_done arrives while idle and must be ignored.
        bad = 0;
        repeat (40) begin tick; if (done !== 2'b00 || gnt !== 2'b00) bad++; end
        checks++; if (bad !== 0) begin errors++; $display("FAIL midrst_stale bad cycles %0d exp 0", bad); end
        delay = 5;
        req1 = 1'b1;
        tick;
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL midrst_regrant got %b exp 10", gnt); end
        wait_start(c);
        checks++; if ({m_addr, m_wdata} !== {7'h56, 8'h77}) begin errors++; $display("FAIL midrst_operands2 got %h exp %h", {m_addr, m_wdata}, {7'h56, 8'h77}); end
        wait_done(c);
        checks++; if ({done, nack} !== 3'b100) begin errors++; $display("FAIL midrst_done got %b exp 100", {done, nack}); end
        req1 = 1'b0;
        tick;
    endtask

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_back_to_back;
        test_nack;
        test_busy;
        test_timeout;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
